// File: rtl/uart_tx_fifo_if.sv
// ============================================================================
//  Module   : uart_tx_fifo_if
//  Brief    : Byte valid/ready handshake into the UART transmit FIFO.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_tx_fifo_if;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;

    modport master (output i_data, output i_valid, input o_ready);
    modport slave  (input i_data, input i_valid, output o_ready);
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module   : uart_tx_fifo
//  Brief    : Buffered 8N1 UART transmitter with internal baud timing.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 4
) (
    input  wire              clk,
    input  wire              reset,
    uart_tx_fifo_if.slave    s_in,
    output logic             o_txd,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_fifo_count
);

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]    c_FULL      = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [c_BAUD_W-1:0] r_baud;
    logic [c_BAUD_W-1:0] w_baud_next;
    logic [2:0]          r_bit_idx;
    logic [2:0]          w_bit_idx_next;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_next;
    logic                r_txd;
    logic                w_txd_next;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic w_ready;
    logic w_push;
    logic w_pop;
    logic w_bit_end;

    // Ready looks only at the registered count, so a full FIFO stays
    // closed even on the cycle it pops.
    assign w_ready   = (r_count != c_FULL);
    assign w_push    = s_in.i_valid && w_ready;
    assign w_pop     = (r_state == c_IDLE) && (r_count != '0);
    assign w_bit_end = (r_baud == c_BAUD_LAST);

    assign s_in.o_ready = w_ready;
    assign o_txd        = r_txd;
    assign o_busy       = (r_state != c_IDLE) || (r_count != '0);
    assign o_fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_pop)                           w_state_next = c_START;
            c_START: if (w_bit_end)                       w_state_next = c_DATA;
            c_DATA:  if (w_bit_end && r_bit_idx == 3'd7)  w_state_next = c_STOP;
            c_STOP:  if (w_bit_end)                       w_state_next = c_IDLE;
            default:                                      w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_baud_next    = w_bit_end ? '0 : r_baud + c_BAUD_W'(1);
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        case (r_state)
            c_IDLE: begin
                w_baud_next    = '0;
                w_bit_idx_next = 3'd0;
                if (w_pop) w_shift_next = r_mem[r_rd_ptr];
            end
            c_START: begin
                if (w_bit_end) w_bit_idx_next = 3'd0;
            end
            c_DATA: begin
                if (w_bit_end) begin
                    w_shift_next   = {1'b0, r_shift[7:1]};
                    w_bit_idx_next = r_bit_idx + 3'd1;
                end
            end
            default: begin
            end
        endcase

        // Line level is registered from the level the next state will drive.
        case (w_state_next)
            c_START: w_txd_next = 1'b0;
            c_DATA:  w_txd_next = w_shift_next[0];
            default: w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_txd     <= 1'b1;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_txd     <= w_txd_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= s_in.i_data;
    end

endmodule

`default_nettype wire
